// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus arbiter and other bus-side blocks.
package bus_pkg;

  localparam int MAX_MASTERS     = 8;
  localparam int DEF_NUM_MASTERS = 2;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MAX_BURST   = 4;
  localparam int DEF_TIMEOUT     = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] searching upward from last+1, wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                       input logic [2:0] last,
                                       input int n);
    rr_pick_t   r;
    logic [2:0] k3;
    r = '0;
    for (int i = 1; i <= MAX_MASTERS; i++) begin
      k3 = 3'((int'(last) + i) % n);
      if (i <= n && !r.found && req[k3]) begin
        r.found = 1'b1;
        r.idx   = k3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder over N requesters.
module rr_picker
  import bus_pkg::*;
#(
  parameter int  N  = DEF_NUM_MASTERS,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [MAX_MASTERS-1:0] req_ext;
  logic [2:0]             last_ext;
  rr_pick_t               r;

  always_comb begin
    req_ext           = '0;
    req_ext[N-1:0]    = req;
    last_ext          = '0;
    last_ext[IW-1:0]  = last;
    r                 = rr_pick(req_ext, last_ext, N);
    found             = r.found && (int'(r.idx) < N);
    idx               = r.idx[IW-1:0];
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the single-port ram bus between NUM_MASTERS requesters.
// Optional lock timeout with sticky arb_error: define BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_BURST   = DEF_MAX_BURST,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_lock,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_address,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_write_data,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic [DATA_W-1:0]             m_read_data,
  output logic [DATA_W-1:0]             bus_address,
  output logic [DATA_W-1:0]             bus_write_data,
  output logic                          bus_write,
  output logic                          bus_read,
  input  logic [DATA_W-1:0]             bus_read_data,
  output logic                          arb_error
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_RST  = IW'(NUM_MASTERS - 1);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  arb_state_t             state;
  logic [IW-1:0]          own;
  logic [IW-1:0]          last;
  logic [BW-1:0]          beats;
  logic [TW-1:0]          lock_cnt;
  logic                   err_q;
  logic                   owned;
  logic                   at_cap;
  logic                   lock_hold;
  logic                   to_fire;
  logic                   release_now;
  logic                   arbitrate;
  logic [NUM_MASTERS-1:0] excl;
  logic [NUM_MASTERS-1:0] pick_req;
  logic                   pick_found;
  logic [IW-1:0]          pick_idx;

  // Release/re-arbitration decision for the coming edge
  always_comb begin
    owned       = (state == OWNED);
    at_cap      = (beats == LAST_BEAT);
    lock_hold   = owned && m_req[own] && m_lock[own] && at_cap;
    to_fire     = TO_EN && lock_hold && (lock_cnt == LOCK_LAST);
    release_now = owned && (!m_req[own] || (at_cap && !m_lock[own]) || to_fire);
    arbitrate   = !owned || release_now;
    excl        = '0;
    // A timed-out owner sits out only the decision that revokes it.
    if (to_fire) excl[own] = 1'b1;
    pick_req    = m_req & ~excl;
  end

  rr_picker #(
    .N (NUM_MASTERS)
  ) u_rr_picker (
    .req   (pick_req),
    .last  (last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      own   <= '0;
      last  <= LAST_RST;
      beats <= '0;
      m_gnt <= '0;
    end else if (arbitrate) begin
      beats <= '0;
      if (pick_found) begin
        state <= OWNED;
        own   <= pick_idx;
        last  <= pick_idx;
        m_gnt <= NUM_MASTERS'(1) << pick_idx;
      end else begin
        state <= IDLE;
        m_gnt <= '0;
      end
    end else if (!at_cap) begin
      beats <= beats + BW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (lock_hold && !arbitrate) lock_cnt <= lock_cnt + TW'(1);
      else                         lock_cnt <= '0;
      if (to_fire) err_q <= 1'b1;
    end
  end

  assign arb_error = TO_EN & err_q;

  // Bus strobes follow the registered owner; nothing reaches ram while idle
  always_comb begin
    bus_address    = '0;
    bus_write_data = '0;
    bus_write      = 1'b0;
    bus_read       = 1'b0;
    if (owned) begin
      bus_address    = m_address[int'(own)*DATA_W +: DATA_W];
      bus_write_data = m_write_data[int'(own)*DATA_W +: DATA_W];
      bus_write      = m_write[own] & m_req[own];
      bus_read       = ~m_write[own] & m_req[own];
    end
  end

  assign m_read_data = bus_read_data;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter with a small behavioural ram.
module tb_bus_arbiter;

  localparam int NM = 2;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int TO = 8;
  localparam logic [31:0] A0 = 32'h10;
  localparam logic [31:0] A1 = 32'h20;
  localparam logic [31:0] D0 = 32'hDEADBEEF;
  localparam logic [31:0] D1 = 32'h5555AAAA;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NM-1:0]     m_req, m_lock, m_write;
  logic [NM*DW-1:0]  m_address, m_write_data;
  logic [NM-1:0]     m_gnt;
  logic [DW-1:0]     m_read_data, bus_address, bus_write_data, bus_read_data;
  logic              bus_write, bus_read, arb_error;

  logic [31:0] ram [0:255] = '{default: 32'h0};

  always #5 clock = ~clock;

  always @(posedge clock) if (bus_write) ram[bus_address[7:0]] <= bus_write_data;
  assign bus_read_data = ram[bus_address[7:0]];

  bus_arbiter #(
    .NUM_MASTERS (NM),
    .DATA_W      (DW),
    .MAX_BURST   (MB),
    .TIMEOUT     (TO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .m_req          (m_req),
    .m_lock         (m_lock),
    .m_write        (m_write),
    .m_address      (m_address),
    .m_write_data   (m_write_data),
    .m_gnt          (m_gnt),
    .m_read_data    (m_read_data),
    .bus_address    (bus_address),
    .bus_write_data (bus_write_data),
    .bus_write      (bus_write),
    .bus_read       (bus_read),
    .bus_read_data  (bus_read_data),
    .arb_error      (arb_error)
  );

  typedef struct packed {
    logic [1:0] gnt;
    logic       bw;
    logic       br;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s @cycle %0d got=%h expected=%h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic push(input int n, input logic [1:0] g, input logic bw, input logic br,
                      input logic err);
    exp_t e;
    e.gnt = g; e.bw = bw; e.br = br; e.err = err;
    repeat (n) sb.push_back(e);
  endtask

  // Compare the current cycle against the oldest expectation.
  task automatic look();
    exp_t        e;
    logic [31:0] ea, ed;
    #1;
    cyc_n++;
    chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      ea = (e.gnt == 2'b01) ? A0 : (e.gnt == 2'b10) ? A1 : 32'h0;
      ed = (e.gnt == 2'b01) ? D0 : (e.gnt == 2'b10) ? D1 : 32'h0;
      chk("m_gnt", 32'(m_gnt), 32'(e.gnt));
      chk("bus_write", 32'(bus_write), 32'(e.bw));
      chk("bus_read", 32'(bus_read), 32'(e.br));
      chk("arb_error", 32'(arb_error), 32'(e.err));
      chk("bus_address", bus_address, ea);
      chk("bus_write_data", bus_write_data, ed);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      look();
      nxt();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    m_req        = '0;
    m_lock       = '0;
    m_write      = '0;
    m_address    = {A1, A0};
    m_write_data = {D1, D0};

    // Reset state
    #12;
    chk("rst_gnt", 32'(m_gnt), 32'd0);
    chk("rst_bus_write", 32'(bus_write), 32'd0);
    chk("rst_bus_read", 32'(bus_read), 32'd0);
    chk("rst_bus_address", bus_address, 32'd0);
    chk("rst_arb_error", 32'(arb_error), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    nxt();

    // Single master write then read-back
    m_req = 2'b01; m_write = 2'b01;
    push(1, 2'b00, 0, 0, 0); run(1);
    push(1, 2'b01, 1, 0, 0); run(1);
    m_write = 2'b00;
    push(1, 2'b01, 0, 1, 0); look();
    chk("read_back", m_read_data, D0);
    chk("ram_written", ram[8'h10], D0);
    nxt();
    m_req = 2'b00;
    push(1, 2'b01, 0, 0, 0); run(1);
    push(1, 2'b00, 0, 0, 0); run(1);

    // Contention, no lock: 4-beat bursts alternate with no idle gap
    m_req = 2'b11; m_write = 2'b01;
    push(1, 2'b00, 0, 0, 0); run(1);
    push(4, 2'b10, 0, 1, 0); run(4);
    push(4, 2'b01, 1, 0, 0); run(4);
    push(3, 2'b10, 0, 1, 0); run(3);
    m_req = 2'b00;
    push(1, 2'b10, 0, 0, 0); run(1);
    push(1, 2'b00, 0, 0, 0); run(1);

    // Lock: master 1 keeps the bus for 10 transfers past the burst cap
    m_req = 2'b10; m_lock = 2'b10;
    push(1, 2'b00, 0, 0, 0); run(1);
    m_req = 2'b11;
    push(10, 2'b10, 0, 1, 0); run(10);
    m_req = 2'b01; m_lock = 2'b00;
    push(1, 2'b10, 0, 0, 0); run(1);
    push(1, 2'b01, 1, 0, 0); run(1);
    m_req = 2'b00;
    push(1, 2'b01, 0, 0, 0); run(1);
    push(1, 2'b00, 0, 0, 0); run(1);

    // Early release at beat 1 hands straight to the waiting master
    m_req = 2'b11;
    push(1, 2'b00, 0, 0, 0); run(1);
    push(1, 2'b10, 0, 1, 0); run(1);
    m_req = 2'b01;
    push(1, 2'b10, 0, 0, 0); run(1);
    push(1, 2'b01, 1, 0, 0); run(1);

    // Reset during master 1's beat 2 drops grant and strobes at once
    m_req = 2'b10; m_write = 2'b00;
    push(1, 2'b01, 0, 0, 0); run(1);
    push(2, 2'b10, 0, 1, 0); run(2);
    m_write = 2'b10;
    push(1, 2'b10, 1, 0, 0); look();
    #1 reset = 1'b0;
    #1;
    chk("midrst_gnt", 32'(m_gnt), 32'd0);
    chk("midrst_bus_write", 32'(bus_write), 32'd0);
    chk("midrst_bus_read", 32'(bus_read), 32'd0);
    m_req = 2'b11; m_write = 2'b01;
    nxt();
    chk("midrst_write_lost", ram[8'h20], 32'h0);
    @(negedge clock);
    reset = 1'b1;
    nxt();

    // Master 0 wins first after reset, then holds its lock indefinitely
    m_lock = 2'b01;
    push(1, 2'b01, 1, 0, 0); run(1);
`ifdef BUS_ARB_TIMEOUT_EN
    push(10, 2'b01, 1, 0, 0); run(10);
    push(4, 2'b10, 0, 1, 1); run(4);
    push(2, 2'b01, 1, 0, 1); run(2);
`else
    push(14, 2'b01, 1, 0, 0); run(14);
`endif

    m_req = 2'b00; m_lock = 2'b00;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
